// File: rtl/tlk2711_rx_checker.sv
// -----------------------------------------------------------------------------
// tlk2711_rx_checker
//
// Purpose:
//   Receive-side frame checker for the TLK2711 SERDES link. It watches the
//   deserialised 16-bit word stream for the comma / SOF / payload framing
//   produced by the transmit-side pattern generator. Each payload word at
//   index k must be {k[7:0], k[7:0]}. The block reports frame pass/fail
//   pulses, a link-lock flag and saturating statistics counters. Everything
//   runs in the receive recovered clock domain.
//
// Ports:
//   clk            in   receive recovered clock
//   rst            in   asynchronous active-high reset
//   i_rxd[15:0]    in   received word ([15:8] MSB byte, [7:0] LSB byte)
//   i_rkmsb        in   K-flag for the MSB byte
//   i_rklsb        in   K-flag for the LSB byte
//   i_clr          in   synchronous clear of the three statistics counters
//   o_data[15:0]   out  last payload word (registered)
//   o_data_valid   out  o_data holds a payload word this cycle
//   o_sof          out  marks the first payload word of a frame
//   o_eof          out  marks the last payload word of a frame
//   o_frame_ok     out  1-cycle pulse: frame complete without errors
//   o_frame_err    out  1-cycle pulse: frame failed or was truncated
//   o_locked       out  link lock status
//   o_frame_cnt    out  good frames (saturating)
//   o_err_cnt      out  failed frames (saturating)
//   o_word_err_cnt out  mismatched payload words (saturating)
// -----------------------------------------------------------------------------
module tlk2711_rx_checker #(
    parameter int DATA_LEN      = 32,
    parameter int LOCK_FRAMES   = 2,
    parameter int UNLOCK_FRAMES = 2,
    parameter int TIMEOUT       = 1024,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      i_rxd,
    input  logic             i_rkmsb,
    input  logic             i_rklsb,
    input  logic             i_clr,
    output logic [15:0]      o_data,
    output logic             o_data_valid,
    output logic             o_sof,
    output logic             o_eof,
    output logic             o_frame_ok,
    output logic             o_frame_err,
    output logic             o_locked,
    output logic [CNT_W-1:0] o_frame_cnt,
    output logic [CNT_W-1:0] o_err_cnt,
    output logic [CNT_W-1:0] o_word_err_cnt
);

    localparam logic [15:0] K_SOF    = 16'hABBC;
    localparam logic [7:0]  LAST_IDX = 8'(DATA_LEN - 1);
    localparam int          GR_W     = $clog2(LOCK_FRAMES + 1);
    localparam int          BR_W     = $clog2(UNLOCK_FRAMES + 1);
    localparam int          WD_W     = $clog2(TIMEOUT + 1);

    typedef enum logic [0:0] {
        ST_HUNT = 1'b0,
        ST_DATA = 1'b1
    } state_t;

    // Frame state
    state_t           state_q, state_d;
    logic [7:0]       idx_q, idx_d;
    logic             ferr_q, ferr_d;     // sticky "this frame has a bad word"
    logic [WD_W-1:0]  wd_q, wd_d;         // cycles since the last SOF
    // Registered outputs
    logic [15:0]      data_q, data_d;
    logic             data_valid_q, data_valid_d;
    logic             sof_q, sof_d;
    logic             eof_q, eof_d;
    logic             frame_ok_q, frame_ok_d;
    logic             frame_err_q, frame_err_d;
    logic             locked_q, locked_d;
    logic [GR_W-1:0]  good_run_q, good_run_d;
    logic [BR_W-1:0]  bad_run_q, bad_run_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] word_err_cnt_q, word_err_cnt_d;

    logic             word_err_s;
    logic             sof_s;
    logic             data_s;
    logic             mismatch_s;
    logic             last_s;
    logic             timeout_s;

    // Word classification. Commas and any other K/data mix need no explicit
    // decode: they are ignored in HUNT and truncate a frame in DATA.
    assign sof_s      = !i_rkmsb && i_rklsb && (i_rxd == K_SOF);
    assign data_s     = !i_rkmsb && !i_rklsb;
    assign mismatch_s = (i_rxd != {idx_q, idx_q});
    assign last_s     = (idx_q == LAST_IDX);
    // Fires once, on the cycle the watchdog would reach TIMEOUT.
    assign timeout_s  = !sof_s && (wd_q == WD_W'(TIMEOUT - 1));

    // State and output register bank
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_HUNT;
            idx_q          <= 8'd0;
            ferr_q         <= 1'b0;
            wd_q           <= '0;
            data_q         <= 16'h0000;
            data_valid_q   <= 1'b0;
            sof_q          <= 1'b0;
            eof_q          <= 1'b0;
            frame_ok_q     <= 1'b0;
            frame_err_q    <= 1'b0;
            locked_q       <= 1'b0;
            good_run_q     <= '0;
            bad_run_q      <= '0;
            frame_cnt_q    <= '0;
            err_cnt_q      <= '0;
            word_err_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            ferr_q         <= ferr_d;
            wd_q           <= wd_d;
            data_q         <= data_d;
            data_valid_q   <= data_valid_d;
            sof_q          <= sof_d;
            eof_q          <= eof_d;
            frame_ok_q     <= frame_ok_d;
            frame_err_q    <= frame_err_d;
            locked_q       <= locked_d;
            good_run_q     <= good_run_d;
            bad_run_q      <= bad_run_d;
            frame_cnt_q    <= frame_cnt_d;
            err_cnt_q      <= err_cnt_d;
            word_err_cnt_q <= word_err_cnt_d;
        end
    end

    // Next-state logic: frame tracking, payload index and error flag
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ferr_d  = ferr_q;
        case (state_q)
            ST_HUNT: begin
                if (sof_s) begin
                    state_d = ST_DATA;
                    idx_d   = 8'd0;
                    ferr_d  = 1'b0;
                end else begin
                    state_d = ST_HUNT;
                end
            end
            ST_DATA: begin
                if (timeout_s) begin
                    state_d = ST_HUNT;
                end else if (data_s) begin
                    idx_d  = idx_q + 8'd1;
                    ferr_d = ferr_q | mismatch_s;
                    if (last_s) begin
                        state_d = ST_HUNT;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else if (sof_s) begin
                    // A new SOF mid-frame restarts reception immediately.
                    state_d = ST_DATA;
                    idx_d   = 8'd0;
                    ferr_d  = 1'b0;
                end else begin
                    state_d = ST_HUNT;
                end
            end
            default: begin
                state_d = ST_HUNT;
            end
        endcase
    end

    // Output decode: payload forwarding and frame result pulses
    always_comb begin
        data_d       = data_q;
        data_valid_d = 1'b0;
        sof_d        = 1'b0;
        eof_d        = 1'b0;
        frame_ok_d   = 1'b0;
        frame_err_d  = 1'b0;
        word_err_s   = 1'b0;
        case (state_q)
            ST_HUNT: begin
                data_valid_d = 1'b0;
            end
            ST_DATA: begin
                if (timeout_s) begin
                    frame_err_d = 1'b1;
                end else if (data_s) begin
                    data_d       = i_rxd;
                    data_valid_d = 1'b1;
                    sof_d        = (idx_q == 8'd0);
                    eof_d        = last_s;
                    word_err_s   = mismatch_s;
                    if (last_s) begin
                        if (ferr_q || mismatch_s) begin
                            frame_err_d = 1'b1;
                        end else begin
                            frame_ok_d = 1'b1;
                        end
                    end else begin
                        frame_ok_d = 1'b0;
                    end
                end else begin
                    // SOF, comma or any other word truncates the frame.
                    frame_err_d = 1'b1;
                end
            end
            default: begin
                data_valid_d = 1'b0;
            end
        endcase
    end

    // SOF watchdog: counts up to TIMEOUT and parks there until the next SOF
    always_comb begin
        if (sof_s) begin
            wd_d = '0;
        end else if (wd_q != WD_W'(TIMEOUT)) begin
            wd_d = wd_q + WD_W'(1);
        end else begin
            wd_d = wd_q;
        end
    end

    // Lock tracking. Acts on the registered result pulses so that o_locked
    // moves one cycle after the pulse that reaches a threshold.
    always_comb begin
        good_run_d = good_run_q;
        bad_run_d  = bad_run_q;
        locked_d   = locked_q;
        if (frame_ok_q) begin
            bad_run_d = '0;
            if (good_run_q != GR_W'(LOCK_FRAMES)) begin
                good_run_d = good_run_q + GR_W'(1);
            end else begin
                good_run_d = good_run_q;
            end
            if (good_run_q >= GR_W'(LOCK_FRAMES - 1)) begin
                locked_d = 1'b1;
            end else begin
                locked_d = locked_q;
            end
        end else if (frame_err_q) begin
            good_run_d = '0;
            if (bad_run_q != BR_W'(UNLOCK_FRAMES)) begin
                bad_run_d = bad_run_q + BR_W'(1);
            end else begin
                bad_run_d = bad_run_q;
            end
            if (bad_run_q >= BR_W'(UNLOCK_FRAMES - 1)) begin
                locked_d = 1'b0;
            end else begin
                locked_d = locked_q;
            end
        end else begin
            locked_d = locked_q;
        end
        // A watchdog expiry overrides any lock progress.
        if (timeout_s) begin
            good_run_d = '0;
            locked_d   = 1'b0;
        end else begin
            good_run_d = good_run_d;
        end
    end

    // Statistics counters: saturating, clear has priority over increment
    always_comb begin
        if (i_clr) begin
            frame_cnt_d = '0;
        end else if (frame_ok_d && (frame_cnt_q != {CNT_W{1'b1}})) begin
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
        end else begin
            frame_cnt_d = frame_cnt_q;
        end

        if (i_clr) begin
            err_cnt_d = '0;
        end else if (frame_err_d && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end else begin
            err_cnt_d = err_cnt_q;
        end

        if (i_clr) begin
            word_err_cnt_d = '0;
        end else if (word_err_s && (word_err_cnt_q != {CNT_W{1'b1}})) begin
            word_err_cnt_d = word_err_cnt_q + CNT_W'(1);
        end else begin
            word_err_cnt_d = word_err_cnt_q;
        end
    end

    assign o_data         = data_q;
    assign o_data_valid   = data_valid_q;
    assign o_sof          = sof_q;
    assign o_eof          = eof_q;
    assign o_frame_ok     = frame_ok_q;
    assign o_frame_err    = frame_err_q;
    assign o_locked       = locked_q;
    assign o_frame_cnt    = frame_cnt_q;
    assign o_err_cnt      = err_cnt_q;
    assign o_word_err_cnt = word_err_cnt_q;

endmodule

// File: tb/tb_tlk2711_rx_checker.sv
// -----------------------------------------------------------------------------
// tb_tlk2711_rx_checker
//
// Directed testbench for tlk2711_rx_checker. The counters are instantiated
// 4 bits wide so saturation is reachable in a short run. Inputs change 1 ns
// after each rising edge, and outputs are sampled at the same point, so every
// check after a step sees the registered response to the word just sent.
// -----------------------------------------------------------------------------
module tb_tlk2711_rx_checker;

    localparam int DATA_LEN = 32;
    localparam int CNT_W    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [15:0]      i_rxd;
    logic             i_rkmsb;
    logic             i_rklsb;
    logic             i_clr;
    logic [15:0]      o_data;
    logic             o_data_valid;
    logic             o_sof;
    logic             o_eof;
    logic             o_frame_ok;
    logic             o_frame_err;
    logic             o_locked;
    logic [CNT_W-1:0] o_frame_cnt;
    logic [CNT_W-1:0] o_err_cnt;
    logic [CNT_W-1:0] o_word_err_cnt;

    int errors = 0;
    int checks = 0;

    tlk2711_rx_checker #(
        .DATA_LEN     (DATA_LEN),
        .LOCK_FRAMES  (2),
        .UNLOCK_FRAMES(2),
        .TIMEOUT      (1024),
        .CNT_W        (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_rxd         (i_rxd),
        .i_rkmsb       (i_rkmsb),
        .i_rklsb       (i_rklsb),
        .i_clr         (i_clr),
        .o_data        (o_data),
        .o_data_valid  (o_data_valid),
        .o_sof         (o_sof),
        .o_eof         (o_eof),
        .o_frame_ok    (o_frame_ok),
        .o_frame_err   (o_frame_err),
        .o_locked      (o_locked),
        .o_frame_cnt   (o_frame_cnt),
        .o_err_cnt     (o_err_cnt),
        .o_word_err_cnt(o_word_err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [15:0] w, input logic km, input logic kl);
        i_rxd   = w;
        i_rkmsb = km;
        i_rklsb = kl;
        @(posedge clk);
        #1;
    endtask

    task automatic comma();
        step(16'hC5BC, 1'b0, 1'b1);
    endtask

    task automatic clear_stats();
        i_clr = 1'b1;
        comma();
        i_clr = 1'b0;
        chk("clr_frame_cnt", 32'(o_frame_cnt), 32'd0);
        chk("clr_err_cnt", 32'(o_err_cnt), 32'd0);
        chk("clr_word_err_cnt", 32'(o_word_err_cnt), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_data"}, 32'(o_data), 32'd0);
        chk({tag, "_valid"}, 32'(o_data_valid), 32'd0);
        chk({tag, "_sof"}, 32'(o_sof), 32'd0);
        chk({tag, "_eof"}, 32'(o_eof), 32'd0);
        chk({tag, "_ok"}, 32'(o_frame_ok), 32'd0);
        chk({tag, "_err"}, 32'(o_frame_err), 32'd0);
        chk({tag, "_locked"}, 32'(o_locked), 32'd0);
        chk({tag, "_frame_cnt"}, 32'(o_frame_cnt), 32'd0);
        chk({tag, "_err_cnt"}, 32'(o_err_cnt), 32'd0);
        chk({tag, "_word_err_cnt"}, 32'(o_word_err_cnt), 32'd0);
    endtask

    // SOF followed by n payload words; word bad_idx (if >= 0) is replaced by
    // bad_word. sof_err: a frame_err pulse is expected on the SOF itself.
    // clr_last: i_clr is raised together with the last word.
    task automatic send_frame(input int n, input int bad_idx, input logic [15:0] bad_word,
                              input logic sof_err, input logic clr_last);
        logic [15:0] w;
        logic [7:0]  k8;
        logic        bad;
        logic        last;
        bad = 1'b0;
        step(16'hABBC, 1'b0, 1'b1);
        chk("sof_step_valid", 32'(o_data_valid), 32'd0);
        chk("sof_step_err", 32'(o_frame_err), 32'(sof_err));
        for (int k = 0; k < n; k++) begin
            k8 = 8'(k);
            w  = {k8, k8};
            if (k == bad_idx) begin
                w   = bad_word;
                bad = 1'b1;
            end
            last = (k == DATA_LEN - 1);
            if (clr_last && (k == n - 1)) begin
                i_clr = 1'b1;
            end
            step(w, 1'b0, 1'b0);
            i_clr = 1'b0;
            chk("word_valid", 32'(o_data_valid), 32'd1);
            chk("word_data", 32'(o_data), 32'(w));
            chk("word_sof", 32'(o_sof), 32'(k == 0));
            chk("word_eof", 32'(o_eof), 32'(last));
            chk("word_frame_ok", 32'(o_frame_ok), 32'(last && !bad));
            chk("word_frame_err", 32'(o_frame_err), 32'(last && bad));
        end
    endtask

    initial begin
        rst     = 1'b1;
        i_rxd   = 16'h0000;
        i_rkmsb = 1'b0;
        i_rklsb = 1'b0;
        i_clr   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // Lock-up: two good frames, lock one cycle after the second pulse
        comma();
        comma();
        chk("hunt_ignores_comma", 32'(o_data_valid), 32'd0);
        step(16'h1234, 1'b0, 1'b0);
        chk("hunt_ignores_data", 32'(o_data_valid), 32'd0);
        send_frame(32, -1, 16'h0000, 1'b0, 1'b0);
        chk("lock1_locked_at_pulse", 32'(o_locked), 32'd0);
        comma();
        chk("lock1_locked_after", 32'(o_locked), 32'd0);
        comma();
        send_frame(32, -1, 16'h0000, 1'b0, 1'b0);
        chk("lock2_locked_at_pulse", 32'(o_locked), 32'd0);
        comma();
        chk("lock2_locked_after", 32'(o_locked), 32'd1);
        chk("lock_frame_cnt", 32'(o_frame_cnt), 32'd2);
        chk("lock_err_cnt", 32'(o_err_cnt), 32'd0);
        chk("lock_word_err_cnt", 32'(o_word_err_cnt), 32'd0);

        // Corrupt word at idx 5: frame error, lock held
        send_frame(32, 5, 16'h0504, 1'b0, 1'b0);
        chk("corrupt_word_err_cnt", 32'(o_word_err_cnt), 32'd1);
        chk("corrupt_err_cnt", 32'(o_err_cnt), 32'd1);
        chk("corrupt_frame_cnt", 32'(o_frame_cnt), 32'd2);
        comma();
        chk("corrupt_locked", 32'(o_locked), 32'd1);
        send_frame(32, -1, 16'h0000, 1'b0, 1'b0);
        comma();
        chk("corrupt_next_frame_cnt", 32'(o_frame_cnt), 32'd3);
        chk("corrupt_next_locked", 32'(o_locked), 32'd1);
        clear_stats();

        // Truncation: 10 words, then a new SOF and a full frame
        send_frame(10, -1, 16'h0000, 1'b0, 1'b0);
        send_frame(32, -1, 16'h0000, 1'b1, 1'b0);
        chk("trunc_err_cnt", 32'(o_err_cnt), 32'd1);
        chk("trunc_frame_cnt", 32'(o_frame_cnt), 32'd1);
        comma();
        chk("trunc_locked", 32'(o_locked), 32'd1);
        // Truncation by a comma: error pulse, no eof
        send_frame(4, -1, 16'h0000, 1'b0, 1'b0);
        comma();
        chk("comma_trunc_err", 32'(o_frame_err), 32'd1);
        chk("comma_trunc_eof", 32'(o_eof), 32'd0);
        chk("comma_trunc_valid", 32'(o_data_valid), 32'd0);
        chk("comma_trunc_err_cnt", 32'(o_err_cnt), 32'd2);
        comma();
        chk("comma_trunc_pulse_len", 32'(o_frame_err), 32'd0);
        clear_stats();
        // Last error cleared bad_run back to 1; a good frame resets it
        send_frame(32, -1, 16'h0000, 1'b0, 1'b0);
        comma();

        // Unlock: two consecutive bad frames
        send_frame(32, 3, 16'hFFFF, 1'b0, 1'b0);
        comma();
        chk("unlock1_locked", 32'(o_locked), 32'd1);
        send_frame(32, 20, 16'h0000, 1'b0, 1'b0);
        chk("unlock2_locked_at_pulse", 32'(o_locked), 32'd1);
        comma();
        chk("unlock2_locked_after", 32'(o_locked), 32'd0);
        chk("unlock_word_err_cnt", 32'(o_word_err_cnt), 32'd2);
        chk("unlock_err_cnt", 32'(o_err_cnt), 32'd2);
        clear_stats();

        // Timeout: re-lock, then only commas after the last SOF
        send_frame(32, -1, 16'h0000, 1'b0, 1'b0);
        comma();
        chk("relock1_locked", 32'(o_locked), 32'd0);
        send_frame(32, -1, 16'h0000, 1'b0, 1'b0);
        // 32 edges since the SOF so far; timeout on edge 1024 = comma 992
        repeat (991) comma();
        chk("timeout_before_locked", 32'(o_locked), 32'd1);
        comma();
        chk("timeout_locked", 32'(o_locked), 32'd0);
        chk("timeout_no_err_in_hunt", 32'(o_frame_err), 32'd0);
        send_frame(32, -1, 16'h0000, 1'b0, 1'b0);
        comma();
        chk("post_timeout1_locked", 32'(o_locked), 32'd0);
        send_frame(32, -1, 16'h0000, 1'b0, 1'b0);
        comma();
        chk("post_timeout2_locked", 32'(o_locked), 32'd1);
        chk("timeout_frame_cnt", 32'(o_frame_cnt), 32'd4);

        // Saturation with 4-bit counters
        clear_stats();
        repeat (15) send_frame(32, -1, 16'h0000, 1'b0, 1'b0);
        chk("sat15_frame_cnt", 32'(o_frame_cnt), 32'd15);
        send_frame(32, -1, 16'h0000, 1'b0, 1'b0);
        chk("sat16_frame_cnt", 32'(o_frame_cnt), 32'd15);
        clear_stats();
        send_frame(32, -1, 16'h0000, 1'b0, 1'b0);
        chk("clr_pre_frame_cnt", 32'(o_frame_cnt), 32'd1);
        send_frame(32, -1, 16'h0000, 1'b0, 1'b1);
        chk("clr_wins_frame_cnt", 32'(o_frame_cnt), 32'd0);
        comma();
        chk("clr_hold_frame_cnt", 32'(o_frame_cnt), 32'd0);
        chk("clr_keeps_lock", 32'(o_locked), 32'd1);

        // Asynchronous reset mid-frame
        send_frame(5, -1, 16'h0000, 1'b0, 1'b0);
        chk("pre_rst_valid", 32'(o_data_valid), 32'd1);
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        #1;
        rst = 1'b0;
        step(16'h0505, 1'b0, 1'b0);
        chk("post_rst_hunt_valid", 32'(o_data_valid), 32'd0);
        chk("post_rst_no_err", 32'(o_frame_err), 32'd0);
        send_frame(32, -1, 16'h0000, 1'b0, 1'b0);
        comma();
        chk("post_rst_locked", 32'(o_locked), 32'd0);
        chk("post_rst_frame_cnt", 32'(o_frame_cnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tlk2711_rx_checker.md
Name: tlk2711_rx_checker

Overview:
Receive-side frame checker for the TLK2711 link; consumes the deserialised 16-bit word stream and K-flags from the SERDES receive interface. Recognises the comma/SOF/payload framing produced by the transmit-side pattern generator and checks every payload word. Reports frame pass/fail, link lock and saturating statistics for ILA/VIO debug and the bring-up software. Runs entirely in the receive clock domain.

Parameters:
DATA_LEN, 32, payload words per frame; legal range 1..256
LOCK_FRAMES, 2, consecutive good frames required to assert lock
UNLOCK_FRAMES, 2, consecutive bad frames that drop lock
TIMEOUT, 1024, cycles without an SOF before lock drops; must be >= DATA_LEN+4
CNT_W, 32, width of the statistics counters

Ports:
clk  in  1  receive recovered clock (TLK2711 RKLSB/RXD domain)
rst  in  1  asynchronous, active-high reset
i_rxd  in  16  received word; [7:0] LSB byte, [15:8] MSB byte
i_rkmsb  in  1  K-flag for MSB byte
i_rklsb  in  1  K-flag for LSB byte
i_clr  in  1  synchronous clear of the statistics counters
o_data  out  16  payload word, registered
o_data_valid  out  1  o_data holds a payload word
o_sof  out  1  with the first payload word of a frame
o_eof  out  1  with the last payload word of a frame
o_frame_ok  out  1  1-cycle pulse: frame complete, no errors
o_frame_err  out  1  1-cycle pulse: frame failed
o_locked  out  1  link lock status
o_frame_cnt  out  CNT_W  good frames
o_err_cnt  out  CNT_W  failed frames
o_word_err_cnt  out  CNT_W  mismatched payload words

Behaviour:
- One clock; reset asynchronous, active-high. On reset, all outputs are 0, state is HUNT and the internal counters are 0.
- Word classes:
  - COMMA: rkmsb=0, rklsb=1, rxd=16'hC5BC.
  - SOF: rkmsb=0, rklsb=1, rxd=16'hABBC.
  - DATA: rkmsb=0, rklsb=0.
  - OTHER: anything else.
- Expected payload word at index k: both bytes equal k[7:0], i.e. {k[7:0],k[7:0]}.
- State HUNT: COMMA, DATA and OTHER are ignored. SOF -> DATA with idx=0 and err flag cleared.
- State DATA, input class DATA:
  - Output the word with o_data_valid=1; o_sof=1 when idx=0; o_eof=1 when idx=DATA_LEN-1.
  - Mismatch: o_word_err_cnt+1 and set the err flag. idx still advances.
  - At idx=DATA_LEN-1: return to HUNT; pulse o_frame_ok, or o_frame_err if the err flag (including this word) is set.
- State DATA, input class COMMA or OTHER (truncated frame):
  - Pulse o_frame_err, no o_eof; go to HUNT.
- State DATA, input class SOF (truncated frame):
  - Pulse o_frame_err; restart DATA with idx=0 and err flag cleared.
- Latency: all outputs are registered, one cycle after the input word's sampling edge.
- Lock:
  - good_run increments on o_frame_ok and resets on o_frame_err; o_locked sets when good_run reaches LOCK_FRAMES.
  - bad_run increments on o_frame_err and resets on o_frame_ok; o_locked clears when bad_run reaches UNLOCK_FRAMES.
  - Both runs saturate at their thresholds.
- Timeout:
  - The SOF watchdog counts cycles since the last SOF and resets on any SOF.
  - On reaching TIMEOUT: o_locked=0, good_run=0, and state forced to HUNT. A frame in progress is abandoned and counted as a frame error.
- Counters: o_frame_cnt +1 per o_frame_ok and o_err_cnt +1 per o_frame_err; all three statistics counters saturate at all-ones.
- i_clr zeroes the three statistics counters next cycle. Clear wins over a simultaneous increment. i_clr does not affect lock, state or the watchdog.
- Reset mid-frame: immediate return to HUNT; no pulse is generated.

Test Plan:
- Lock-up: 2x COMMA, SOF, 32 words 16'h0000..16'h1F1F, repeated twice -> o_frame_ok pulses 2x, o_locked=1 one cycle after the second pulse, o_frame_cnt=2, o_err_cnt=0; o_sof with 16'h0000, o_eof with 16'h1F1F.
- Corrupt word: in a locked stream, payload idx 5 sent as 16'h0504 -> o_word_err_cnt=1, o_frame_err at frame end, no o_frame_ok, o_locked stays 1; next good frame -> o_frame_ok.
- Truncation: SOF, 10 good words, then SOF and a full frame -> o_frame_err one cycle after the second SOF, then o_frame_ok; o_err_cnt=1, o_frame_cnt=1.
- Unlock: locked, then two frames each with one bad word -> o_locked falls one cycle after the second o_frame_err.
- Timeout: locked, then 1024 cycles of COMMA only -> o_locked=0 at cycle 1024; a subsequent SOF plus a good frame is counted but not locked until the second good frame.
- Clear/saturation: with CNT_W=4, 16 good frames -> o_frame_cnt=15; i_clr asserted in the same cycle as an o_frame_ok increment -> count 0; async rst asserted mid-frame -> all outputs 0 immediately.
